// File: rtl/instr_packer.sv
// RV32I instruction packer: encodes field bundles into 32-bit words and streams
// them with sequential imem word addresses through a two-stage valid/ready pipe.
module instr_packer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  localparam int unsigned INSTR_W = 32;
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic               s1_valid;
  logic [2:0]         s1_fmt;
  logic [6:0]         s1_opcode;
  logic [4:0]         s1_rd;
  logic [4:0]         s1_rs1;
  logic [4:0]         s1_rs2;
  logic [2:0]         s1_funct3;
  logic [6:0]         s1_funct7;
  logic [31:0]        s1_imm;
  logic               s1_err;
  logic               s1_ready;
  logic               s2_ready;
  logic               s1_load;
  logic               s2_load;
  logic               imm_err_c;
  logic [INSTR_W-1:0] pack_c;
  logic [ADDR_W-1:0]  addr_cnt;

  // Handshake: reset and flush both block new input.
  assign s2_ready = !out_valid | out_ready;
  assign s1_ready = !s1_valid | s2_ready;
  assign in_ready = s1_ready & !flush & rst_n;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid & s2_ready & !flush;

  // Immediate range check per format; illegal formats always error.
  always_comb begin
    imm_err_c = 1'b0;
    case (in_fmt)
      FMT_R:        imm_err_c = 1'b0;
      FMT_I, FMT_S: imm_err_c = !((&in_imm[31:11]) | !(|in_imm[31:11]));
      FMT_B:        imm_err_c = in_imm[0] | !((&in_imm[31:12]) | !(|in_imm[31:12]));
      FMT_U:        imm_err_c = |in_imm[11:0];
      FMT_J:        imm_err_c = in_imm[0] | !((&in_imm[31:20]) | !(|in_imm[31:20]));
      default:      imm_err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
      s1_err    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_fmt    <= in_fmt;
        s1_opcode <= in_opcode;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_funct3 <= in_funct3;
        s1_funct7 <= in_funct7;
        s1_imm    <= in_imm;
        s1_err    <= imm_err_c;
      end
    end
  end

  // Field packing; out-of-range immediates are simply truncated.
  always_comb begin
    pack_c = INSTR_W'(0);
    case (s1_fmt)
      FMT_R: pack_c = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: pack_c = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: pack_c = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: pack_c = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                       s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: pack_c = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: pack_c = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      default: pack_c = INSTR_W'(0);
    endcase
  end

  // Output stage, address counter and error/wrap bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE;
      out_err   <= 1'b0;
      addr_cnt  <= BASE;
      wrapped   <= 1'b0;
      err_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      addr_cnt  <= BASE;
      wrapped   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (s2_ready) out_valid <= s1_valid;
      if (s2_load) begin
        out_instr <= pack_c;
        out_err   <= s1_err;
        out_addr  <= addr_cnt;
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        if (addr_cnt == ADDR_MAX) wrapped <= 1'b1;
      end
      if (out_valid && out_ready && out_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: queue-based reference model checked every cycle,
// plus literal expectations for encodings, back-pressure, wrap, flush and reset.
module tb_instr_packer;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [7:0]    err_cnt;
  logic          wrapped;

  instr_packer #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder written as plain shift/mask arithmetic.
  function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: return (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      3'd1: return ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7);
      3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                   (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd4: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                   (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                   (32'(rd) << 7) | 32'(op);
      default: return 32'h0;
    endcase
  endfunction

  // Reference range check using signed value bounds.
  function automatic logic bad(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = imm;
    case (f)
      3'd0: return 1'b0;
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (imm[0] == 1'b1) || (s < -4096) || (s > 4095);
      3'd4: return (imm % 32'd4096) != 32'd0;
      3'd5: return (imm[0] == 1'b1) || (s < -1048576) || (s > 1048575);
      default: return 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
    logic          wr;
    int            acc;
  } exp_t;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
  } dl_t;

  exp_t q[$];
  dl_t  dlog[$];
  int   cyc = 0;
  int   last_deliv = 0;
  int   mcnt = 0;
  int   merr = 0;
  logic mwrap = 1'b0;
  logic last_wr = 1'b0;

  task automatic model_clear();
    q.delete();
    mcnt = 0;
    merr = 0;
    mwrap = 1'b0;
    last_wr = 1'b0;
    last_deliv = 0;
  endtask

  // Model: words enter the queue on accept and leave on delivery.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      model_clear();
    end else begin
      cyc++;
      if (flush) begin
        model_clear();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_delivery: got word 0x%0h expected none", out_instr);
          end else begin
            e = q.pop_front();
            dlog.push_back('{out_instr, out_addr, out_err});
            last_wr = e.wr;
            last_deliv = cyc;
            if (e.err && merr < 255) merr++;
          end
        end
        if (in_valid && in_ready) begin
          e.instr = enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
          e.err   = bad(in_fmt, in_imm);
          e.addr  = AW'(mcnt);
          if (mcnt == (1 << AW) - 1) mwrap = 1'b1;
          e.wr    = mwrap;
          e.acc   = cyc;
          mcnt    = (mcnt + 1) % (1 << AW);
          q.push_back(e);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic ev;
    logic exp_rdy;
    int   vis;
    if (rst_n) begin
      ev = 1'b0;
      if (q.size() > 0) begin
        vis = (q[0].acc + 1 > last_deliv) ? q[0].acc + 1 : last_deliv;
        ev = (cyc >= vis);
      end
      exp_rdy = !flush && (!ev || out_ready || (q.size() < 2));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev && out_valid) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        chk("out_err", 32'(out_err), 32'(q[0].err));
        chk("wrapped", 32'(wrapped), 32'(q[0].wr));
      end else if (!ev) begin
        chk("wrapped_idle", 32'(wrapped), 32'(last_wr));
      end
      chk("err_cnt", 32'(err_cnt), 32'(merr));
      if (q.size() > 2) begin
        checks++;
        errors++;
        $display("FAIL occupancy: got %0d words in flight expected at most 2", q.size());
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return r;
      1: return {{20{r[11]}}, r[11:0]};
      2: return {{19{r[12]}}, r[12:1], 1'b0};
      3: return {{11{r[20]}}, r[20:1], 1'b0};
      default: return {r[31:12], 12'h000};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int k;
    logic a;
    logic [31:0] w;

    // Reset values while rst_n is held low.
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Two-stage latency on an I-type word.
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("lat_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_stage1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_stage2_valid", 32'(out_valid), 32'd1);
    chk("lat_instr", out_instr, 32'hFFF00093);
    chk("lat_addr", 32'(out_addr), 32'd0);
    chk("lat_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;

    // B/J/U encodings with incrementing addresses.
    do_flush();
    b = dlog.size();
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    idle(4);
    chk("bju_count", 32'(dlog.size() - b), 32'd3);
    if (dlog.size() - b == 3) begin
      chk("b_instr", dlog[b].instr, 32'hFE208EE3);
      chk("j_instr", dlog[b+1].instr, 32'h008000EF);
      chk("u_instr", dlog[b+2].instr, 32'h123452B7);
      for (int i = 0; i < 3; i++) chk("bju_addr", 32'(dlog[b+i].addr), 32'(i));
    end

    // Range errors and illegal format.
    do_flush();
    b = dlog.size();
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(3'd6, 7'h7F, 5'd3, 5'd4, 5'd5, 3'd7, 7'h7F, 32'd5);
    idle(4);
    chk("err_count_words", 32'(dlog.size() - b), 32'd3);
    if (dlog.size() - b == 3) begin
      w = dlog[b].instr;
      chk("i2048_err", 32'(dlog[b].err), 32'd1);
      chk("i2048_imm", 32'(w[31:20]), 32'h800);
      chk("b3_err", 32'(dlog[b+1].err), 32'd1);
      chk("fmt6_instr", dlog[b+2].instr, 32'd0);
      chk("fmt6_err", 32'(dlog[b+2].err), 32'd1);
    end
    chk("err_cnt_3", 32'(err_cnt), 32'd3);

    // Error counter saturation.
    do_flush();
    for (int i = 0; i < 300; i++) send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(4);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Back-pressure: only two bundles fit while the output stalls.
    do_flush();
    b = dlog.size();
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(3'd0, 7'b0110011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      if (a) k++;
    end
    chk("bp_accepted", 32'(k), 32'd2);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int j = k; j < 4; j++) send(3'd0, 7'b0110011, 5'(j), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(5);
    chk("bp_delivered", 32'(dlog.size() - b), 32'd4);
    if (dlog.size() - b == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bp_order", dlog[b+i].instr, (32'(i) << 7) | 32'h33);
        chk("bp_addr", 32'(dlog[b+i].addr), 32'(i));
      end
    end

    // Address wrap, then flush with a bundle offered.
    do_flush();
    b = dlog.size();
    for (int i = 0; i < 5; i++) send(3'd0, 7'b0110011, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(4);
    chk("wrap_count", 32'(dlog.size() - b), 32'd5);
    if (dlog.size() - b == 5) begin
      for (int i = 0; i < 5; i++) chk("wrap_addr", 32'(dlog[b+i].addr), 32'(i % 4));
    end
    chk("wrap_flag", 32'(wrapped), 32'd1);
    drive(3'd0, 7'b0110011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_wrapped", 32'(wrapped), 32'd0);
    @(posedge clk); #1;
    b = dlog.size();
    send(3'd0, 7'b0110011, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(4);
    chk("post_flush_count", 32'(dlog.size() - b), 32'd1);
    if (dlog.size() - b == 1) begin
      chk("post_flush_addr", 32'(dlog[b].addr), 32'd0);
      chk("post_flush_instr", dlog[b].instr, (32'd10 << 7) | 32'h33);
    end

    // Random traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      flush     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_opcode = 7'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = rnd_imm();
      @(posedge clk); #1;
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(5);

    // Asynchronous reset with words in flight.
    send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(3);
    out_ready = 1'b0;
    send(3'd0, 7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'b0110011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_out_instr", out_instr, 32'd0);
    chk("async_out_addr", 32'(out_addr), 32'd0);
    chk("async_out_err", 32'(out_err), 32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_wrapped", 32'(wrapped), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    b = dlog.size();
    send(3'd0, 7'b0110011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle(4);
    chk("post_reset_count", 32'(dlog.size() - b), 32'd1);
    if (dlog.size() - b == 1) chk("post_reset_addr", 32'(dlog[b].addr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
